// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity mode constants for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: frame serializer (FSM, bit counter, shift register) with registered tx
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick_i,
  input  logic                 word_valid_i,
  input  logic [DATA_BITS-1:0] word_i,
  output logic                 load_o,
  output logic                 tx_o,
  output logic                 idle_o
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d, tx_q, tx_d, take;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    take    = 1'b0;
    if (baud_tick_i) begin
      case (state_q)
        ST_IDLE:   take = word_valid_i;
        ST_START:  begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
        ST_DATA:   begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_DATA) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            cnt_d   = '0;
          end
        end
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            take    = word_valid_i;
            state_d = ST_IDLE;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
    // a load from holding restarts the frame straight into START, even from the last stop bit
    if (take) begin
      state_d = ST_START;
      shift_d = word_i;
      par_d   = ^word_i;
      cnt_d   = '0;
    end
    load_o = take;
    tx_d   = (state_d == ST_START)  ? 1'b0 :
             (state_d == ST_DATA)   ? shift_d[0] :
             (state_d == ST_PARITY) ? ((PARITY == PARITY_ODD) ? ~par_q : par_q) : 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end
  assign tx_o   = tx_q;
  assign idle_o = (state_q == ST_IDLE);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-word holding register and valid/ready handshake
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d, accept, load, idle;
  assign accept = in_valid & in_ready;
  // accept and load are mutually exclusive: accept needs holding empty, load needs it full
  always_comb begin
    full_d = accept ? 1'b1 : load ? 1'b0 : full_q;
    hold_d = accept ? in_data : hold_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end
  uart_tx_shifter #(
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .baud_tick_i (baud_tick),
    .word_valid_i(full_q),
    .word_i      (hold_q),
    .load_o      (load),
    .tx_o        (tx),
    .idle_o      (idle)
  );
  assign in_ready = ~full_q;
  assign busy     = ~idle | full_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx in 8N1, 8E1, 8O1 and 8N2 configurations
module tb_uart_tx;
  logic       clk = 1'b0, reset = 1'b0, baud_tick = 1'b0;
  logic [7:0] in_data[4];
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready, tx, busy;
  int tick_per = 16, tick_cnt = 0, bp = 16;
  int n_chk = 0, n_pass = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS(8),
      .PARITY   (g == 1 ? 1 : g == 2 ? 2 : 0),
      .STOP_BITS(g == 3 ? 2 : 1)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .baud_tick(baud_tick),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .tx       (tx[g]),
      .busy     (busy[g])
    );
  end

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_per == 0) baud_tick = 1'b0;
    else begin
      baud_tick = (tick_cnt == 0);
      tick_cnt  = (tick_cnt + 1) % tick_per;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // expected line levels of one frame, from the framing rules
  function automatic logic [12:0] frame_of(input int idx, input logic [7:0] w, output int n);
    logic [12:0] f = '1;
    int par = (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
    int stops = (idx == 3) ? 2 : 1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = w[i];
    n = 9;
    if (par != 0) begin
      f[n] = (^w) ^ (par == 2);
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  task automatic send(input int idx, input logic [7:0] w);
    int k = 0;
    @(negedge clk);
    in_data[idx]  = w;
    in_valid[idx] = 1'b1;
    while (!in_ready[idx] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("accept d%0d w%02h", idx, w), 32'(k < 3000), 1);
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  task automatic check_frame(input int idx, input logic [7:0] w, input bit wait_edge);
    int n, k = 0;
    logic [12:0] f = frame_of(idx, w, n);
    if (wait_edge) begin
      while (tx[idx] !== 1'b0 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("start_seen d%0d w%02h", idx, w), 32'(k < 3000), 1);
      repeat (bp / 2) @(negedge clk);
    end else repeat (bp) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("d%0d w%02h bit%0d", idx, w, i), 32'(tx[idx]), 32'(f[i]));
      if (i < n - 1) repeat (bp) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] w0, w1, w2;
    int k;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx d%0d", i), 32'(tx[i]), 1);
      chk($sformatf("rst_ready d%0d", i), 32'(in_ready[i]), 1);
      chk($sformatf("rst_busy d%0d", i), 32'(busy[i]), 0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    fork
      send(0, 8'h55);
      check_frame(0, 8'h55, 1);
    join
    repeat (bp) @(negedge clk);
    chk("idle_after_55", 32'(tx[0]), 1);
    chk("busy_after_55", 32'(busy[0]), 0);

    for (int d = 1; d <= 2; d++) begin
      fork
        send(d, 8'hA5);
        check_frame(d, 8'hA5, 1);
      join
    end

    fork
      begin
        send(0, 8'h01);
        send(0, 8'h80);
        chk("ready_while_held", 32'(in_ready[0]), 0);
        chk("busy_while_held", 32'(busy[0]), 1);
      end
      begin
        check_frame(0, 8'h01, 1);
        check_frame(0, 8'h80, 0);
      end
    join

    fork
      begin
        send(3, 8'hFF);
        send(3, 8'hFF);
      end
      begin
        check_frame(3, 8'hFF, 1);
        check_frame(3, 8'hFF, 0);
      end
    join

    // abort mid data bit 3 with a second word waiting in holding
    repeat (bp) @(negedge clk);
    fork
      begin
        send(0, 8'h3C);
        send(0, 8'($urandom));
      end
      begin
        k = 0;
        while (tx[0] !== 1'b0 && k < 3000) begin
          @(negedge clk);
          k++;
        end
        chk("abort_start_seen", 32'(k < 3000), 1);
        repeat (bp / 2 + 4 * bp) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx", 32'(tx[0]), 1);
        chk("abort_ready", 32'(in_ready[0]), 1);
        chk("abort_busy", 32'(busy[0]), 0);
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3 * bp) @(negedge clk);
    chk("post_abort_tx", 32'(tx[0]), 1);
    chk("post_abort_busy", 32'(busy[0]), 0);
    fork
      send(0, 8'h3C);
      check_frame(0, 8'h3C, 1);
    join

    tick_per = 0;
    w0 = 8'($urandom);
    @(negedge clk);
    in_data[0]  = w0;
    in_valid[0] = 1'b1;
    repeat (100) @(negedge clk);
    chk("notick_ready", 32'(in_ready[0]), 0);
    chk("notick_busy", 32'(busy[0]), 1);
    chk("notick_tx", 32'(tx[0]), 1);
    in_valid[0] = 1'b0;
    in_data[0]  = ~w0;
    tick_per = 16;
    check_frame(0, w0, 1);

    for (int r = 0; r < 2; r++) begin
      bp = r ? 1 : 16;
      tick_per = bp;
      for (int d = 0; d < 4; d++) begin
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        repeat (2 * bp) @(negedge clk);
        fork
          begin
            send(d, w0);
            send(d, w1);
            send(d, w2);
          end
          begin
            check_frame(d, w0, 1);
            check_frame(d, w1, 0);
            check_frame(d, w2, 0);
          end
        join
        repeat (bp) @(negedge clk);
        chk($sformatf("rand_idle d%0d", d), 32'(tx[d]), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-002 Parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1 or 2.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 baud_tick  input  1  one-clk-wide bit-period strobe from the upstream clock divider.
REQ-007 in_data  input  DATA_BITS  byte to transmit.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block can accept in_data this cycle.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  a frame is on the line or a word is held.

Function
REQ-012 The block SHALL hold one word in a holding register; in_ready SHALL equal "holding register empty".
REQ-013 A transfer SHALL occur on a posedge where in_valid and in_ready are both 1; in_data SHALL be captured then; in_valid with in_ready 0 SHALL be ignored, with no data loss for in_data held stable.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; all state advances SHALL occur only on clk edges where baud_tick is 1.
REQ-015 IDLE: tx 1; on baud_tick with holding full, the word SHALL move to the shift register, holding SHALL become empty, and the state SHALL become START.
REQ-016 START: tx 0 for one bit period; then DATA.
REQ-017 DATA: tx SHALL drive shift register bit 0 (LSB first), shifting on each baud_tick; after DATA_BITS periods go to PARITY if PARITY != 0, else STOP.
REQ-018 PARITY: tx SHALL be XOR of all data bits (even) or its inverse (odd) for one period.
REQ-019 STOP: tx 1 for STOP_BITS periods; on the final tick, go to START with a load from holding if holding is full (no idle gap), else IDLE.
REQ-020 Latency: first start bit SHALL appear on the clk after the first baud_tick following acceptance; a tick in the acceptance cycle itself SHALL not start the frame.
REQ-021 A word accepted while a frame is in progress SHALL wait in holding; in_ready SHALL stay 0 until it is loaded into the shift register.
REQ-022 Load and new acceptance SHALL not coincide in one cycle, because in_ready is 0 while holding is full.
REQ-023 tx SHALL be a registered output, glitch-free.
REQ-024 busy SHALL be 1 when state != IDLE or holding is full.
REQ-025 baud_tick asserted on consecutive clks SHALL advance one bit per tick; no internal rate check.

Reset
REQ-026 reset low SHALL immediately force state IDLE, tx 1, holding empty, in_ready 1, busy 0, shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame and discard held data; tx SHALL return high asynchronously.
REQ-028 After reset release, the first accepted word SHALL transmit normally.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state encoding and the PARITY encoding constants (NONE, EVEN, ODD).
REQ-030 The serializer (shift register, bit counter, FSM) SHALL be one sub-module, uart_tx_shifter; the holding register and handshake SHALL stay in uart_tx.
REQ-031 baud_tick SHALL come from an externally instantiated clock divider; uart_tx SHALL contain no baud divider.

Verification
REQ-032 8N1, tick every 16 clks, send 0x55 -> tx per bit period 0,1,0,1,0,1,0,1,0,1 then idle 1.
REQ-033 PARITY=1, send 0xA5 -> start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1; with PARITY=2 -> parity 1.
REQ-034 Send 0x01 then 0x80 back-to-back -> in_ready drops after 0x80 is held; second start bit directly follows first stop bit, with no extra idle period.
REQ-035 STOP_BITS=2, send 0xFF -> tx high for exactly 2 bit periods after data before the next start.
REQ-036 Assert reset low during DATA bit 3 of 0x3C -> tx 1 at once, in_ready 1, busy 0; then 0x3C sent after release -> complete correct frame.
REQ-037 in_valid held with no baud_tick for 100 clks -> one word accepted, tx stays 1, busy 1, in_ready 0.
